// File: rtl/icache_controller_if.sv
// Fetch-side bundle for the instruction cache: PC stage and instruction-memory signals.
interface icache_controller_if #(
    parameter int unsigned MEM_ADDR_W = 6
);
    logic [31:0]           PC;
    logic [31:0]           INSTRUCTION;
    logic                  BUSYWAIT;
    logic                  MEM_READ;
    logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
    logic [127:0]          MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    // Cache controller side.
    modport master (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    // PC stage plus instruction memory side.
    modport slave (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: 8 lines x 16-byte blocks, refilled from
// instruction memory over a MEM_READ/MEM_BUSYWAIT handshake.
module icache_controller #(
    parameter int unsigned LINES          = 8,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned MEM_ADDR_W     = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    icache_controller_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    state_t state, state_next;

    logic [LINES-1:0]               valid;
    logic [2:0]                     tag_store  [LINES];
    logic [WORDS_PER_LINE*32-1:0]   data_store [LINES];

    logic [1:0] offset;
    logic [2:0] index;
    logic [2:0] tag;
    logic       hit;
    logic       unused;

    assign offset = bus.PC[3:2];
    assign index  = bus.PC[6:4];
    assign tag    = bus.PC[9:7];
    assign unused = ^{bus.PC[31:10], bus.PC[1:0]};

    assign hit = valid[index] && (tag_store[index] == tag);

    // Word select is unconditional; the word is only meaningful while BUSYWAIT is low.
    assign bus.INSTRUCTION = data_store[index][{offset, 5'd0} +: 32];
    assign bus.MEM_ADDRESS = bus.PC[MEM_ADDR_W+3:4];

    // State register; reset abandons any fill in progress.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    // Valid bits: cleared by reset, set when a refill lands.
    always_ff @(posedge CLK) begin
        if (RESET)                  valid        <= '0;
        else if (state == S_UPDATE) valid[index] <= 1'b1;
    end

    // Tag and data arrays: written at the UPDATE edge only, never cleared.
    always_ff @(posedge CLK) begin
        if (!RESET && state == S_UPDATE) begin
            data_store[index] <= bus.MEM_READDATA;
            tag_store[index]  <= tag;
        end
    end

    // Next-state and handshake outputs; BUSYWAIT is held low during reset.
    always_comb begin
        state_next   = state;
        bus.MEM_READ = 1'b0;
        bus.BUSYWAIT = 1'b0;
        case (state)
            S_IDLE: begin
                if (!hit) begin
                    bus.BUSYWAIT = 1'b1;
                    state_next   = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                bus.MEM_READ = 1'b1;
                bus.BUSYWAIT = 1'b1;
                if (!bus.MEM_BUSYWAIT) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                bus.BUSYWAIT = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (RESET) bus.BUSYWAIT = 1'b0;
    end
endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: each task drives one scenario and checks inline.
module tb_icache_controller;
    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    icache_controller_if bus ();

    icache_controller #(
        .LINES(8),
        .WORDS_PER_LINE(4),
        .MEM_ADDR_W(6)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory image: every word holds its own byte address within the 1 KiB space.
    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [127:0] r;
        for (int unsigned i = 0; i < 4; i++) begin
            logic [1:0] w;
            w = 2'(i);
            r[i*32 +: 32] = {22'd0, a, w, 2'b00};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one full miss/refill with the given memory latency and records what the DUT showed.
    task automatic run_fill(input logic [31:0] pc, input int lat,
                            output logic busy0, output logic rd1, output logic [5:0] addr1,
                            output logic upd_busy, output logic upd_rd,
                            output logic done_busy, output logic [31:0] instr);
        bus.PC           = pc;
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = blk(pc[9:4]);
        #1;
        busy0 = bus.BUSYWAIT;
        tick();
        rd1   = bus.MEM_READ;
        addr1 = bus.MEM_ADDRESS;
        repeat (lat - 1) tick();
        tick();
        bus.MEM_BUSYWAIT = 1'b0;
        #1;
        tick();
        upd_busy = bus.BUSYWAIT;
        upd_rd   = bus.MEM_READ;
        bus.MEM_BUSYWAIT = 1'b1;
        tick();
        done_busy = bus.BUSYWAIT;
        instr     = bus.INSTRUCTION;
    endtask

    task automatic test_reset();
        RESET            = 1'b1;
        bus.PC           = 'x;
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = '0;
        repeat (2) tick();
        total++;
        if (bus.BUSYWAIT !== 1'b0) begin
            $display("FAIL reset_busywait got=%b want=0", bus.BUSYWAIT); bad++;
        end
        total++;
        if (bus.MEM_READ !== 1'b0) begin
            $display("FAIL reset_mem_read got=%b want=0", bus.MEM_READ); bad++;
        end
        bus.PC = 32'h0;
    endtask

    task automatic test_cold_miss();
        logic b0, r1, ub, ur, db;
        logic [5:0] a1;
        logic [31:0] ins;
        RESET = 1'b0;
        run_fill(32'h00, 20, b0, r1, a1, ub, ur, db, ins);
        total++;
        if (b0 !== 1'b1) begin $display("FAIL cold_busy_immediate got=%b want=1", b0); bad++; end
        total++;
        if (r1 !== 1'b1 || a1 !== 6'd0) begin
            $display("FAIL cold_mem_req got=%b/%h want=1/00", r1, a1); bad++;
        end
        total++;
        if (ub !== 1'b1 || ur !== 1'b0) begin
            $display("FAIL cold_update got=busy%b/rd%b want=busy1/rd0", ub, ur); bad++;
        end
        total++;
        if (db !== 1'b0) begin $display("FAIL cold_busy_release got=%b want=0", db); bad++; end
        total++;
        if (ins !== 32'h0) begin $display("FAIL cold_instr got=%h want=00000000", ins); bad++; end
    endtask

    task automatic test_sequential_hits();
        logic [31:0] pcs [3];
        pcs[0] = 32'h04; pcs[1] = 32'h08; pcs[2] = 32'h0C;
        for (int i = 0; i < 3; i++) begin
            bus.PC = pcs[i];
            #1;
            total++;
            if (bus.BUSYWAIT !== 1'b0 || bus.MEM_READ !== 1'b0 || bus.INSTRUCTION !== pcs[i]) begin
                $display("FAIL seq_hit pc=%h got=busy%b rd%b ins=%h want=busy0 rd0 ins=%h",
                         pcs[i], bus.BUSYWAIT, bus.MEM_READ, bus.INSTRUCTION, pcs[i]);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_conflict_eviction();
        logic b0, r1, ub, ur, db;
        logic [5:0] a1;
        logic [31:0] ins;
        run_fill(32'h80, 3, b0, r1, a1, ub, ur, db, ins);
        total++;
        if (b0 !== 1'b1 || a1 !== 6'b001000 || r1 !== 1'b1) begin
            $display("FAIL evict_miss got=busy%b rd%b addr=%h want=busy1 rd1 addr=08", b0, r1, a1); bad++;
        end
        total++;
        if (db !== 1'b0 || ins !== 32'h80) begin
            $display("FAIL evict_fill got=busy%b ins=%h want=busy0 ins=00000080", db, ins); bad++;
        end
        run_fill(32'h00, 3, b0, r1, a1, ub, ur, db, ins);
        total++;
        if (b0 !== 1'b1 || a1 !== 6'd0) begin
            $display("FAIL evict_return got=busy%b addr=%h want=busy1 addr=00", b0, a1); bad++;
        end
        total++;
        if (ins !== 32'h0) begin $display("FAIL evict_return_instr got=%h want=00000000", ins); bad++; end
    endtask

    task automatic test_wrap_alias();
        logic b0, r1, ub, ur, db;
        logic [5:0] a1;
        logic [31:0] ins;
        run_fill(32'h7C, 4, b0, r1, a1, ub, ur, db, ins);
        total++;
        if (b0 !== 1'b1 || a1 !== 6'd7) begin
            $display("FAIL wrap_miss got=busy%b addr=%h want=busy1 addr=07", b0, a1); bad++;
        end
        total++;
        if (ins !== 32'h7C) begin $display("FAIL wrap_instr got=%h want=0000007c", ins); bad++; end
        bus.PC = 32'h47C;
        #1;
        total++;
        if (bus.BUSYWAIT !== 1'b0 || bus.INSTRUCTION !== 32'h7C) begin
            $display("FAIL alias_hit got=busy%b ins=%h want=busy0 ins=0000007c",
                     bus.BUSYWAIT, bus.INSTRUCTION); bad++;
        end
        tick();
        total++;
        if (bus.MEM_READ !== 1'b0) begin $display("FAIL alias_no_read got=%b want=0", bus.MEM_READ); bad++; end
    endtask

    task automatic test_reset_mid_fill();
        logic b0, r1, ub, ur, db;
        logic [5:0] a1;
        logic [31:0] ins;
        bus.PC           = 32'h10;
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = blk(6'd1);
        #1;
        tick();
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        total++;
        if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b0) begin
            $display("FAIL midfill_reset got=rd%b busy%b want=rd0 busy0", bus.MEM_READ, bus.BUSYWAIT); bad++;
        end
        bus.MEM_BUSYWAIT = 1'b0;
        tick();
        bus.MEM_BUSYWAIT = 1'b1;
        RESET = 1'b0;
        #1;
        total++;
        if (bus.BUSYWAIT !== 1'b1 || bus.MEM_READ !== 1'b0) begin
            $display("FAIL midfill_rearm got=busy%b rd%b want=busy1 rd0", bus.BUSYWAIT, bus.MEM_READ); bad++;
        end
        run_fill(32'h10, 2, b0, r1, a1, ub, ur, db, ins);
        total++;
        if (a1 !== 6'd1 || db !== 1'b0 || ins !== 32'h10) begin
            $display("FAIL midfill_refill got=addr%h busy%b ins=%h want=addr01 busy0 ins=00000010", a1, db, ins); bad++;
        end
    endtask

    task automatic test_reset_collision();
        bus.PC           = 32'h20;
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = blk(6'd2);
        #1;
        tick();
        repeat (2) tick();
        RESET            = 1'b1;
        bus.MEM_BUSYWAIT = 1'b0;
        #1;
        tick();
        total++;
        if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b0) begin
            $display("FAIL collide_reset got=rd%b busy%b want=rd0 busy0", bus.MEM_READ, bus.BUSYWAIT); bad++;
        end
        RESET            = 1'b0;
        bus.MEM_BUSYWAIT = 1'b1;
        #1;
        total++;
        if (bus.BUSYWAIT !== 1'b1 || bus.MEM_READ !== 1'b0) begin
            $display("FAIL collide_miss got=busy%b rd%b want=busy1 rd0", bus.BUSYWAIT, bus.MEM_READ); bad++;
        end
        bus.PC = 32'h7C;
        #1;
        total++;
        if (bus.BUSYWAIT !== 1'b1) begin
            $display("FAIL collide_valid_cleared got=busy%b want=1", bus.BUSYWAIT); bad++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cold_miss();
        test_sequential_hits();
        test_conflict_eviction();
        test_wrap_alias();
        test_reset_mid_fill();
        test_reset_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
